// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the multicycle Booth multiplier.
package mult_pkg;

  localparam int WIDTH   = 32;
  localparam int ITER    = 32;
  localparam int COUNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// 32-bit adder built from 4-bit lookahead groups, with signed overflow
// and signed compare side outputs.
module carry_lookahead_adder #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c0,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             AleB,
  output logic             AneB
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Each group resolves its internal carries from its own generate/propagate
  // bits; only the group carry-out is handed to the next group.
  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    logic [3:0] w_gl;
    logic [3:0] w_pl;
    logic       w_ci;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_co;

    if (k == 0) begin : g_first
      assign w_ci = c0;
    end else begin : g_next
      assign w_ci = g_grp[k-1].w_co;
    end

    assign w_gl = w_g[4*k +: 4];
    assign w_pl = w_p[4*k +: 4];

    assign w_c1 = w_gl[0] | (w_pl[0] & w_ci);
    assign w_c2 = w_gl[1] | (w_pl[1] & w_gl[0]) | (&w_pl[1:0] & w_ci);
    assign w_c3 = w_gl[2] | (w_pl[2] & w_gl[1]) | (&w_pl[2:1] & w_gl[0])
                | (&w_pl[2:0] & w_ci);
    assign w_co = w_gl[3] | (w_pl[3] & w_gl[2]) | (&w_pl[3:2] & w_gl[1])
                | (&w_pl[3:1] & w_gl[0]) | (&w_pl[3:0] & w_ci);

    assign out[4*k +: 4] = w_pl ^ {w_c3, w_c2, w_c1, w_ci};
  end

  assign ovf  = g_grp[GROUPS-1].w_co ^ g_grp[GROUPS-1].w_c3;
  assign AleB = ($signed(A) <= $signed(B));
  assign AneB = |w_p;

endmodule

// File: rtl/mult_sequencer.sv
// Multicycle signed 32x32 multiplier: radix-2 Booth over one shared adder,
// returning the low product word and a does-not-fit-in-32-bits flag.
module mult_sequencer #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int ITER  = mult_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  import mult_pkg::COUNT_W;
  import mult_pkg::state_t;
  import mult_pkg::S_IDLE;
  import mult_pkg::S_RUN;
  import mult_pkg::S_DONE;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_q_m1;
  logic [COUNT_W-1:0]   r_count;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exception;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_add_b;
  logic                 w_c0;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_ovf;
  logic                 w_sign;
  logic [WIDTH-1:0]     w_hi_next;
  logic [WIDTH-1:0]     w_lo_next;

  assign w_accept = ctrl_MULT && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_count == COUNT_W'(ITER - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_MULT) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = ctrl_MULT ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_add_b = '0;
    w_c0    = 1'b0;
    case ({r_lo[0], r_q_m1})
      2'b01: w_add_b = r_m;
      2'b10: begin
        w_add_b = ~r_m;
        w_c0    = 1'b1;
      end
      default: w_add_b = '0;
    endcase
  end

  carry_lookahead_adder #(
    .WIDTH (WIDTH)
  ) u_cla (
    .A    (r_hi),
    .B    (w_add_b),
    .c0   (w_c0),
    .out  (w_sum),
    .ovf  (w_ovf),
    .AleB (),
    .AneB ()
  );

  // The true sign of hi+/-M is the sum MSB corrected by overflow, which keeps
  // the arithmetic shift right even for M = most-negative.
  assign w_sign    = w_sum[WIDTH-1] ^ w_ovf;
  assign w_hi_next = {w_sign, w_sum[WIDTH-1:1]};
  assign w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_q_m1      <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (w_accept) begin
      r_m     <= data_operandA;
      r_hi    <= '0;
      r_lo    <= data_operandB;
      r_q_m1  <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_q_m1  <= r_lo[0];
      r_count <= r_count + COUNT_W'(1);
      if (w_last) begin
        r_result    <= w_lo_next;
        r_exception <= (w_hi_next != {WIDTH{w_lo_next[WIDTH-1]}});
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: driver pushes 64-bit reference
// products, a negedge monitor pops and compares on every result pulse.
module tb_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  mult_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    exp_t   e;
    p     = longint'(signed'(a)) * longint'(signed'(b));
    e.res = p[31:0];
    e.exc = (p[63:32] != {32{p[31]}});
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return 32'($urandom_range(0, 65535));
      5:       return -32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    exp_q.push_back(ref_mul(a, b));
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Entered at the first negedge after accept; returns at the RDY negedge.
  task automatic wait_done(input int pulse_at, output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == pulse_at) begin
        ctrl_MULT     = 1'b1;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end else if (k == pulse_at + 1) begin
        ctrl_MULT = 1'b0;
      end
      if (busy === 1'b1) bsy++;
      if (data_resultRDY === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    if (lat == 0) check("rdy_timeout", {31'b0, data_resultRDY}, 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rdy_without_op", {31'b0, data_resultRDY}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", data_result, e.res);
          check("exception", {31'b0, data_exception}, {31'b0, e.exc});
        end
      end
    end
  end

  initial begin : driver
    int          lat;
    int          bsy;
    int          rdy_cnt;
    logic [31:0] ta [5];
    logic [31:0] tb [5];

    ta = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'h0001_0000};
    tb = '{32'd4, 32'h0000_0006, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0000};

    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (ta[i]) begin
      start(ta[i], tb[i]);
      wait_done(0, lat, bsy);
      check("latency", lat, 32'd33);
      check("busy_cycles", bsy, 32'd32);
      repeat (2) @(negedge clock);
    end

    // Re-pulse mid-RUN is ignored; pulse in DONE chains with no idle cycle.
    start(32'd3, 32'd4);
    wait_done(10, lat, bsy);
    check("latency_repulse", lat, 32'd33);
    start(32'd5, 32'hFFFF_FFF7);
    wait_done(0, lat, bsy);
    check("latency_b2b", lat, 32'd33);
    check("busy_b2b", bsy, 32'd32);
    @(negedge clock);
    check("held_result", data_result, 32'hFFFF_FFD3);

    // Reset at RUN cycle 15 aborts the operation.
    start(32'h1234_5678, 32'h0000_0100);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    check("abort_result", data_result, 32'd0);
    check("abort_exception", {31'b0, data_exception}, 32'd0);
    check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    check("abort_no_rdy", rdy_cnt, 32'd0);

    // Reset and start on the same edge: reset wins.
    reset     = 1'b1;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    check("reset_beats_start", {31'b0, busy}, 32'd0);
    @(negedge clock);

    for (int n = 0; n < 1000; n++) begin
      start(pick(), pick());
      wait_done(0, lat, bsy);
      check("latency_rand", lat, 32'd33);
      if ($urandom_range(0, 1) == 0) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
